// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one main-memory port between the instruction-side
// and data-side cache requesters. Round-robin grant, one block-aligned
// command per grant, a BURST_LEN-beat data phase, and a watchdog that aborts
// a transaction when the memory side stops making progress.
//
// Command handshake: MEM_VALID is high for every cycle in CMD and holds
// MEM_WE/MEM_ADDR stable; the command transfers on the cycle where
// MEM_VALID && MEM_READY. MEM_VALID only drops without MEM_READY when the
// watchdog aborts the command. Data beats have no valid from this side:
// each MEM_BEAT_ACK seen in DATA completes exactly one beat.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         REQ_I,
  input  logic [ADDR_W-1:0]            ADDR_I,
  input  logic                         REQ_D,
  input  logic                         WE_D,
  input  logic [ADDR_W-1:0]            ADDR_D,
  input  logic [DATA_W-1:0]            WDATA_D,
  output logic                         GNT_I,
  output logic                         GNT_D,
  output logic                         BEAT_I,
  output logic                         BEAT_D,
  output logic [$clog2(BURST_LEN)-1:0] BEAT_IDX,
  output logic [DATA_W-1:0]            RDATA,
  output logic                         DONE_I,
  output logic                         DONE_D,
  output logic                         ERR_I,
  output logic                         ERR_D,
  output logic                         MEM_VALID,
  output logic                         MEM_WE,
  output logic [ADDR_W-1:0]            MEM_ADDR,
  input  logic                         MEM_READY,
  output logic [DATA_W-1:0]            MEM_WDATA,
  input  logic                         MEM_BEAT_ACK,
  input  logic [DATA_W-1:0]            MEM_RDATA,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Byte address with the block offset (beat index + 4-byte word) cleared.
  localparam logic [ADDR_W-1:0] ADDR_MASK =
    ~((ADDR_W'(1) << (IDX_W + 2)) - ADDR_W'(1));

  // The progress edge itself counts as cycle 0, so the abort lands in RESP
  // exactly TIMEOUT cycles after the last MEM_READY / MEM_BEAT_ACK (or after
  // the grant edge if the command is never accepted).
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 2);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              owner_d_q;  // 1: D side owns the current transaction
  logic              last_d_q;   // 1: D side was served most recently
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;
  logic              beat_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req_any;
  logic              pick_d;
  logic              progress;
  logic              wd_expire;
  logic              last_beat;

  // Arbitration and progress decode shared by next-state and datapath logic.
  always_comb begin
    req_any   = REQ_I | REQ_D;
    pick_d    = REQ_D & (~REQ_I | ~last_d_q);
    progress  = ((state_q == S_CMD)  & MEM_READY) |
                ((state_q == S_DATA) & MEM_BEAT_ACK);
    wd_expire = ~progress & (wd_q == WD_LIMIT);
    last_beat = (idx_q == LAST_IDX);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) state_d = S_CMD;
      end
      S_CMD: begin
        if (MEM_READY)      state_d = S_DATA;
        else if (wd_expire) state_d = S_RESP;
      end
      S_DATA: begin
        if (MEM_BEAT_ACK && last_beat) state_d = S_RESP;
        else if (wd_expire)            state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction datapath: latched command, beat counter, watchdog, read data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_d_q <= 1'b0;
      last_d_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      idx_q     <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      beat_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      beat_q <= (state_q == S_DATA) & MEM_BEAT_ACK;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            owner_d_q <= pick_d;
            we_q      <= pick_d & WE_D;
            addr_q    <= (pick_d ? ADDR_D : ADDR_I) & ADDR_MASK;
            idx_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
          end
        end
        S_CMD: begin
          if (MEM_READY)      wd_q  <= '0;
          else if (wd_expire) err_q <= 1'b1;
          else                wd_q  <= wd_q + WD_W'(1);
        end
        S_DATA: begin
          if (MEM_BEAT_ACK) begin
            wd_q  <= '0;
            idx_q <= idx_q + IDX_W'(1);
            if (!we_q) rdata_q <= MEM_RDATA;
          end else if (wd_expire) begin
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_RESP: begin
          last_d_q <= owner_d_q;
          idx_q    <= '0;
          wd_q     <= '0;
        end
        default: begin
          idx_q <= '0;
        end
      endcase
    end
  end

  // Output decode from state and the latched transaction.
  always_comb begin
    GNT_I     = (state_q != S_IDLE) & ~owner_d_q;
    GNT_D     = (state_q != S_IDLE) &  owner_d_q;
    BEAT_I    = beat_q & ~owner_d_q;
    BEAT_D    = beat_q &  owner_d_q;
    DONE_I    = (state_q == S_RESP) & ~owner_d_q;
    DONE_D    = (state_q == S_RESP) &  owner_d_q;
    ERR_I     = (state_q == S_RESP) & err_q & ~owner_d_q;
    ERR_D     = (state_q == S_RESP) & err_q &  owner_d_q;
    MEM_VALID = (state_q == S_CMD);
    MEM_WE    = we_q;
    MEM_ADDR  = addr_q;
    MEM_WDATA = ((state_q == S_DATA) && we_q) ? WDATA_D : '0;
    BEAT_IDX  = idx_q;
    RDATA     = rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: zero-wait read, round-robin order,
// delayed-accept write, watchdog abort, mid-burst reset, early REQ drop.
module tb_mem_bus_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 64;

  logic              CLK;
  logic              RST_N;
  logic              REQ_I;
  logic [ADDR_W-1:0] ADDR_I;
  logic              REQ_D;
  logic              WE_D;
  logic [ADDR_W-1:0] ADDR_D;
  logic [DATA_W-1:0] WDATA_D;
  logic              GNT_I, GNT_D, BEAT_I, BEAT_D;
  logic [1:0]        BEAT_IDX;
  logic [DATA_W-1:0] RDATA;
  logic              DONE_I, DONE_D, ERR_I, ERR_D;
  logic              MEM_VALID, MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_READY;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_BEAT_ACK;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Store data the D requester offers for the beat currently in progress.
  logic [DATA_W-1:0] wtab [4];
  assign WDATA_D = wtab[BEAT_IDX];

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_I(REQ_I), .ADDR_I(ADDR_I),
    .REQ_D(REQ_D), .WE_D(WE_D), .ADDR_D(ADDR_D), .WDATA_D(WDATA_D),
    .GNT_I(GNT_I), .GNT_D(GNT_D), .BEAT_I(BEAT_I), .BEAT_D(BEAT_D),
    .BEAT_IDX(BEAT_IDX), .RDATA(RDATA),
    .DONE_I(DONE_I), .DONE_D(DONE_D), .ERR_I(ERR_I), .ERR_D(ERR_D),
    .MEM_VALID(MEM_VALID), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_READY(MEM_READY), .MEM_WDATA(MEM_WDATA),
    .MEM_BEAT_ACK(MEM_BEAT_ACK), .MEM_RDATA(MEM_RDATA),
    .dbg_state(dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, 64'({GNT_I, GNT_D, BEAT_I, BEAT_D, DONE_I, DONE_D,
                             ERR_I, ERR_D, MEM_VALID, MEM_WE}), 64'(0));
    chk({tag, ".idx"},   64'(BEAT_IDX),  64'(0));
    chk({tag, ".rdata"}, 64'(RDATA),     64'(0));
    chk({tag, ".addr"},  64'(MEM_ADDR),  64'(0));
    chk({tag, ".wdata"}, 64'(MEM_WDATA), 64'(0));
    chk({tag, ".state"}, 64'(dbg_state), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    step();
    step();
    chk_zero(tag);
    RST_N = 1'b1;
    step();
  endtask

  // One complete transaction with a cooperative memory. Entered in the IDLE
  // cycle where the request(s) are already driven; leaves in the IDLE cycle
  // after DONE, with the served side's REQ dropped.
  task automatic txn(input string tag, input logic exp_d, input logic exp_we,
                     input logic [31:0] exp_addr, input int ready_wait,
                     input bit drop_early, input logic [31:0] rbase);
    logic [1:0] side;
    side = exp_d ? 2'b01 : 2'b10;
    chk({tag, ".idle_gnt"}, 64'({GNT_I, GNT_D}), 64'(0));
    step();
    chk({tag, ".gnt"},       64'({GNT_I, GNT_D}), 64'(side));
    chk({tag, ".valid"},     64'(MEM_VALID), 64'(1));
    chk({tag, ".addr"},      64'(MEM_ADDR),  64'(exp_addr));
    chk({tag, ".we"},        64'(MEM_WE),    64'(exp_we));
    chk({tag, ".wdata_cmd"}, 64'(MEM_WDATA), 64'(0));
    for (int i = 0; i < ready_wait; i++) begin
      MEM_READY = 1'b0;
      step();
      chk({tag, ".valid_hold"}, 64'(MEM_VALID), 64'(1));
      chk({tag, ".addr_hold"},  64'(MEM_ADDR),  64'(exp_addr));
    end
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    chk({tag, ".valid_drop"}, 64'(MEM_VALID), 64'(0));
    if (drop_early) begin
      if (exp_d) REQ_D = 1'b0;
      else       REQ_I = 1'b0;
    end
    for (int b = 0; b < BURST_LEN; b++) begin
      MEM_BEAT_ACK = 1'b1;
      MEM_RDATA    = rbase + 32'(b);
      chk({tag, ".idx"},   64'(BEAT_IDX),  64'(b));
      chk({tag, ".wdata"}, 64'(MEM_WDATA), exp_we ? 64'(32'h11 * (b + 1)) : 64'(0));
      if (!exp_we) exp_q.push_back(rbase + 32'(b));
      step();
      MEM_BEAT_ACK = 1'b0;
      MEM_RDATA    = '0;
      chk({tag, ".beat"}, 64'({BEAT_I, BEAT_D}), 64'(side));
      if (!exp_we) chk({tag, ".rdata"}, 64'(RDATA), 64'(exp_q.pop_front()));
      chk({tag, ".done"}, 64'({DONE_I, DONE_D}), (b == BURST_LEN - 1) ? 64'(side) : 64'(0));
    end
    chk({tag, ".err"},      64'({ERR_I, ERR_D}), 64'(0));
    chk({tag, ".gnt_resp"}, 64'({GNT_I, GNT_D}), 64'(side));
    chk({tag, ".idx_wrap"}, 64'(BEAT_IDX), 64'(0));
    if (exp_d) REQ_D = 1'b0;
    else       REQ_I = 1'b0;
    step();
    chk({tag, ".idle"}, 64'({GNT_I, GNT_D, DONE_I, DONE_D, BEAT_I, BEAT_D}), 64'(0));
  endtask

  int k;

  initial begin
    wtab[0] = 32'h11; wtab[1] = 32'h22; wtab[2] = 32'h33; wtab[3] = 32'h44;
    RST_N = 1'b0;
    REQ_I = 1'b0; ADDR_I = '0;
    REQ_D = 1'b0; WE_D = 1'b0; ADDR_D = '0;
    MEM_READY = 1'b0; MEM_BEAT_ACK = 1'b0; MEM_RDATA = '0;

    // Reset state
    do_reset("rst");

    // Zero-wait I read: DONE on the 6th cycle after REQ
    REQ_I = 1'b1; ADDR_I = 32'h0000_1234;
    txn("rd_i", 1'b0, 1'b0, 32'h0000_1230, 0, 1'b0, 32'hA0);

    // Round robin from reset: D, then I, then D; WE_D ignored for I
    do_reset("rst2");
    REQ_I = 1'b1; ADDR_I = 32'h0000_1234;
    REQ_D = 1'b1; WE_D = 1'b1; ADDR_D = 32'h0000_0ABC;
    txn("rr1_d", 1'b1, 1'b1, 32'h0000_0AB0, 0, 1'b0, 32'h0);
    REQ_D = 1'b1;
    txn("rr2_i", 1'b0, 1'b0, 32'h0000_1230, 0, 1'b0, 32'hB0);
    REQ_I = 1'b1;
    txn("rr3_d", 1'b1, 1'b1, 32'h0000_0AB0, 0, 1'b0, 32'h0);
    REQ_I = 1'b0;
    step();

    // D write with MEM_READY delayed 3 cycles
    REQ_D = 1'b1; WE_D = 1'b1; ADDR_D = 32'h0000_0040;
    txn("wr_d", 1'b1, 1'b1, 32'h0000_0040, 3, 1'b0, 32'h0);
    chk("wr_d.done_once", 64'({DONE_I, DONE_D}), 64'(0));

    // Watchdog: accepted command, no beat acks ever
    REQ_D = 1'b1; WE_D = 1'b0; ADDR_D = 32'h0000_0100;
    step();
    chk("to.gnt", 64'({GNT_I, GNT_D}), 64'(2'b01));
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    k = 1;
    while (DONE_D !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("to.cycles",  64'(k), 64'(TIMEOUT));
    chk("to.err",     64'({ERR_I, ERR_D}), 64'(2'b01));
    chk("to.valid",   64'(MEM_VALID), 64'(0));
    chk("to.gnt_resp", 64'({GNT_I, GNT_D}), 64'(2'b01));
    chk("to.beat",    64'({BEAT_I, BEAT_D}), 64'(0));
    REQ_D = 1'b0;
    step();
    chk("to.idle", 64'({GNT_D, DONE_D, ERR_D}), 64'(0));
    REQ_I = 1'b1; ADDR_I = 32'h0000_3008;
    txn("to_next", 1'b0, 1'b0, 32'h0000_3000, 1, 1'b0, 32'hC0);

    // Reset during beat 2 of a read
    REQ_I = 1'b1; ADDR_I = 32'h0000_2004;
    step();
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    MEM_BEAT_ACK = 1'b1; MEM_RDATA = 32'hE0;
    step();
    MEM_RDATA = 32'hE1;
    step();
    chk("mid.idx", 64'(BEAT_IDX), 64'(2));
    MEM_BEAT_ACK = 1'b0; MEM_RDATA = '0;
    REQ_I = 1'b0;
    RST_N = 1'b0;
    #1;
    chk_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid.no_done", 64'({DONE_I, DONE_D}), 64'(0));
    end
    RST_N = 1'b1;
    step();
    chk("mid.post_state", 64'(dbg_state), 64'(0));
    REQ_I = 1'b1; ADDR_I = 32'h0000_501C;
    txn("post_rst", 1'b0, 1'b0, 32'h0000_5010, 0, 1'b0, 32'hF0);

    // REQ_D dropped right after grant: burst still completes
    REQ_D = 1'b1; WE_D = 1'b0; ADDR_D = 32'h0000_0084;
    txn("drop_d", 1'b1, 1'b0, 32'h0000_0080, 0, 1'b1, 32'hD0);

    chk("scoreboard.empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between two cache requesters: instruction side (I) and data side (D).
- Performs round-robin arbitration and issues one block-aligned command per grant.
- Sequences the BURST_LEN-beat data phase and returns a per-requester completion or error pulse.
- A watchdog aborts a transaction when the memory side stops making progress.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits
BURST_LEN, 4, words per block transfer; power of two, at least 2
TIMEOUT, 64, consecutive no-progress cycles before abort; at least 2

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_I  in  1  I-side read request; held high until DONE_I
ADDR_I  in  ADDR_W  I-side byte address
REQ_D  in  1  D-side request; held high until DONE_D
WE_D  in  1  D-side write enable (1 = block store)
ADDR_D  in  ADDR_W  D-side byte address
WDATA_D  in  DATA_W  D-side write word for the current BEAT_IDX
GNT_I, GNT_D  out  1  grant, high from command issue through the DONE cycle
BEAT_I, BEAT_D  out  1  one-cycle strobe per completed beat
BEAT_IDX  out  log2(BURST_LEN)  current beat number within the burst
RDATA  out  DATA_W  registered read word, valid while BEAT_x is high
DONE_I, DONE_D  out  1  one-cycle completion pulse
ERR_I, ERR_D  out  1  one-cycle pulse coincident with DONE_x when a timeout aborted the transaction
MEM_VALID  out  1  command valid to memory
MEM_WE  out  1  command type (1 = write)
MEM_ADDR  out  ADDR_W  block-aligned command address
MEM_READY  in  1  memory accepts the command
MEM_WDATA  out  DATA_W  write beat data (combinational pass-through of WDATA_D)
MEM_BEAT_ACK  in  1  beat complete: read word present on MEM_RDATA, or write word consumed
MEM_RDATA  in  DATA_W  read beat data

Behaviour:
Reset (RST_N low, asynchronous):
- All outputs 0; state IDLE; beat counter 0; watchdog counter 0.
- LAST = I, so the D side wins the first tie.
- Reset mid-transaction abandons it with no DONE pulse. Memory must be reset together with this block.

State machine: IDLE, CMD, DATA, RESP.
- IDLE:
  - Only one of REQ_I/REQ_D high: grant that side.
  - Both high: grant the side not equal to LAST.
  - At grant, latch the requester, WE (forced 0 for I) and the address with the low log2(BURST_LEN)+2 bits cleared.
  - Next cycle: GNT_x=1, MEM_VALID=1, state CMD.
- CMD:
  - Hold MEM_VALID, MEM_WE and MEM_ADDR stable until MEM_READY=1.
  - On the MEM_READY cycle: MEM_VALID drops next cycle and state moves to DATA.
  - MEM_BEAT_ACK is ignored in CMD.
- DATA:
  - Each MEM_BEAT_ACK registers RDATA (reads only), pulses BEAT_x the following cycle and increments BEAT_IDX.
  - MEM_WDATA = WDATA_D while in DATA with MEM_WE=1, else 0. The requester updates WDATA_D on each BEAT_D.
  - The ack for beat BURST_LEN-1 moves the state to RESP. BEAT_IDX wraps to 0.
- RESP (one cycle):
  - DONE_x=1, GNT_x still 1, LAST updated to the served side.
  - Next state IDLE, where GNT_x drops.
  - A REQ still high in IDLE is a new request. The requester drops REQ in the cycle it sees DONE.

Other rules:
- A requester dropping REQ after grant has no effect; the transaction completes.
- Watchdog:
  - Counts every cycle in CMD and DATA; cleared by MEM_READY in CMD, by MEM_BEAT_ACK in DATA, and on entering CMD.
  - Reaching TIMEOUT forces RESP with DONE_x=ERR_x=1 and MEM_VALID=0. LAST still updates.
- MEM_READY high in the first CMD cycle is legal (zero-wait accept).
- MEM_BEAT_ACK in consecutive cycles is legal (one beat per cycle).
- Latency, read, zero wait: REQ at cycle 0, GNT/MEM_VALID at 1, MEM_READY at 1, acks at 2–5, BEAT_x at 3–6, DONE at 6. The DONE (RESP) cycle coincides with the BEAT_x pulse of the final beat.
- Minimum spacing between two commands: 2 cycles after DONE (RESP, then IDLE).

Test Plan:
- REQ_I=1, ADDR_I=0x0000_1234, memory zero-wait, RDATA words A0..A3 -> MEM_ADDR=0x0000_1230, MEM_WE=0, BEAT_I at cycles 3–6 carrying A0..A3, BEAT_IDX 0..3, DONE_I at 6, ERR_I=0.
- REQ_I and REQ_D rise together from reset, then both re-request on their DONE -> D served first, then I, then D; GNT_I and GNT_D never both high.
- D write to ADDR_D=0x40, WDATA_D stepping 0x11, 0x22, 0x33, 0x44 on BEAT_D, MEM_READY delayed 3 cycles -> MEM_VALID held 4 cycles with stable address, MEM_WDATA sequence 0x11..0x44, DONE_D once.
- Memory never asserts MEM_BEAT_ACK after accept, TIMEOUT=64 -> DONE_D and ERR_D pulse exactly 64 cycles after MEM_READY; the next request is served normally.
- RST_N pulsed low during beat 2 of a read -> all outputs 0 immediately, no DONE; a fresh REQ_I after release completes normally.
- REQ_D dropped one cycle after GNT_D -> burst still completes with 4 beats and DONE_D.
